// File: rtl/fetch_unit.sv
// -----------------------------------------------------------------------------
// fetch_unit -- instruction-fetch front end and PC controller for the pipelined
// Beta CPU.
//
// Issues one instruction-memory request at a time at the PC's current address,
// buffers returned words for decode, and advances the PC by strobing its clock
// enable. Execute-stage branch/jump resolutions are turned into the PC's
// pcsel/pc_in/offset/address controls, and wrong-path work is flushed.
//
// Optional build macro: FETCH_STATS_EN adds stat_fetched/stat_flushed counters.
//
// Ports:
//   clk, rst        clock, asynchronous active-low reset
//   clk_en          global enable; low only blocks issuing new fetches
//   pc_cur, pc_nxt  PC current / next address
//   pc_clk_en, pcsel, pc_in, pc_offset, pc_address
//                   combinational PC controls (pcsel: 00 NORMAL, 01 BEQ,
//                   10 JMP, 11 BNE)
//   imem_req, imem_addr          registered memory request
//   imem_ack, imem_rdata         memory response (1-cycle ack pulse)
//   ir_valid, ir_data, ir_pc     instruction buffer head
//   ir_ready                     decode accepts head
//   br_valid, br_type, br_pc, br_offset, br_reg_val, br_target
//                                execute-stage branch resolution
//   stat_fetched, stat_flushed   (FETCH_STATS_EN only) event counters
// -----------------------------------------------------------------------------
module fetch_unit #(
  parameter int DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        clk_en,
  input  logic [31:0] pc_cur,
  input  logic [31:0] pc_nxt,
  output logic        pc_clk_en,
  output logic [1:0]  pcsel,
  output logic [31:0] pc_in,
  output logic [15:0] pc_offset,
  output logic [31:0] pc_address,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        ir_valid,
  output logic [31:0] ir_data,
  output logic [31:0] ir_pc,
  input  logic        ir_ready,
  input  logic        br_valid,
  input  logic [1:0]  br_type,
  input  logic [31:0] br_pc,
  input  logic [15:0] br_offset,
  input  logic [31:0] br_reg_val,
  input  logic [31:0] br_target
`ifdef FETCH_STATS_EN
  ,
  output logic [31:0] stat_fetched,
  output logic [31:0] stat_flushed
`endif
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_REQ   = 2'd1;
  localparam logic [1:0] S_FLUSH = 2'd2;

  localparam logic [1:0] SEL_NORMAL = 2'b00;
  localparam logic [1:0] SEL_BEQ    = 2'b01;
  localparam logic [1:0] SEL_JMP    = 2'b10;
  localparam logic [1:0] SEL_BNE    = 2'b11;

  logic [1:0]    state;
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic [31:0]   data_q [DEPTH];
  logic [31:0]   pc_q   [DEPTH];

  logic taken, push, pop;

  assign taken = br_valid & ((br_type == SEL_JMP) |
                             ((br_type == SEL_BEQ) & (br_reg_val == 32'd0)) |
                             ((br_type == SEL_BNE) & (br_reg_val != 32'd0)));

  // A response is kept only when it answers a live request and no redirect
  // arrives in the same cycle; late acks in IDLE never match S_REQ.
  assign push = (state == S_REQ) & imem_ack & ~taken;
  assign pop  = ir_valid & ir_ready;

  assign ir_valid = (count != '0);
  assign ir_data  = ir_valid ? data_q[rd_ptr] : 32'd0;
  assign ir_pc    = ir_valid ? pc_q[rd_ptr]   : 32'd0;

  // PC controls. Held at zero during reset so the PC sees no stray strobe.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves one unassigned
    // and no latch is inferred.
    pc_clk_en  = 1'b0;
    pcsel      = SEL_NORMAL;
    pc_in      = rst ? pc_nxt : 32'd0;
    pc_offset  = 16'd0;
    pc_address = 32'd0;
    if (rst) begin
      if (taken) begin
        // The PC subtracts 4 internally, so br_pc+8 lands on br_pc+4+4*offset.
        pc_clk_en  = 1'b1;
        pcsel      = br_type;
        pc_in      = br_pc + 32'd8;
        pc_offset  = br_offset;
        pc_address = (br_type == SEL_JMP) ? br_target : br_reg_val;
      end else if (push) begin
        pc_clk_en = 1'b1;
      end
    end
  end

  // Request FSM.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= S_IDLE;
      imem_req  <= 1'b0;
      imem_addr <= 32'd0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples pre-edge values regardless of statement order.
      case (state)
        S_IDLE: begin
          if (clk_en && (count < DEPTH_C) && !taken) begin
            imem_req  <= 1'b1;
            imem_addr <= pc_cur;
            state     <= S_REQ;
          end
        end
        S_REQ: begin
          if (imem_ack) begin
            imem_req <= 1'b0;
            state    <= S_IDLE;
          end else if (taken) begin
            state <= S_FLUSH;
          end
        end
        S_FLUSH: begin
          // The wrong-path response still has to drain before a new request.
          if (imem_ack) begin
            imem_req <= 1'b0;
            state    <= S_IDLE;
          end
        end
        default: begin
          imem_req <= 1'b0;
          state    <= S_IDLE;
        end
      endcase
    end
  end

  // Buffer pointers and occupancy; a flush overrides any same-cycle pop.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (taken) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      count <= count + CW'(push) - CW'(pop);
    end
  end

  // NOTE: buffer storage is not reset; count gates every read, so its
  // contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (push) begin
      data_q[wr_ptr] <= imem_rdata;
      pc_q[wr_ptr]   <= imem_addr;
    end
  end

`ifdef FETCH_STATS_EN
  logic drop;
  assign drop = imem_ack & (((state == S_REQ) & taken) | (state == S_FLUSH));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stat_fetched <= 32'd0;
      stat_flushed <= 32'd0;
    end else begin
      stat_fetched <= stat_fetched + 32'(push);
      stat_flushed <= stat_flushed + 32'(drop) + (taken ? 32'(count) : 32'd0);
    end
  end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// -----------------------------------------------------------------------------
// tb_fetch_unit -- self-checking bench for fetch_unit (DEPTH=2).
// Inputs change 1 time unit after a rising edge; outputs are checked between
// edges. A small external-PC model follows pc_clk_en/pcsel. Pushed words go
// into a scoreboard queue and are compared when decode pops them.
// -----------------------------------------------------------------------------
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        clk_en;
  logic [31:0] pc_cur, pc_nxt;
  logic        pc_clk_en;
  logic [1:0]  pcsel;
  logic [31:0] pc_in;
  logic [15:0] pc_offset;
  logic [31:0] pc_address;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        ir_valid;
  logic [31:0] ir_data, ir_pc;
  logic        ir_ready;
  logic        br_valid;
  logic [1:0]  br_type;
  logic [31:0] br_pc;
  logic [15:0] br_offset;
  logic [31:0] br_reg_val, br_target;
`ifdef FETCH_STATS_EN
  logic [31:0] stat_fetched, stat_flushed;
`endif

  fetch_unit #(.DEPTH(2)) dut (
    .clk(clk), .rst(rst), .clk_en(clk_en),
    .pc_cur(pc_cur), .pc_nxt(pc_nxt),
    .pc_clk_en(pc_clk_en), .pcsel(pcsel), .pc_in(pc_in),
    .pc_offset(pc_offset), .pc_address(pc_address),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .ir_valid(ir_valid), .ir_data(ir_data), .ir_pc(ir_pc), .ir_ready(ir_ready),
    .br_valid(br_valid), .br_type(br_type), .br_pc(br_pc),
    .br_offset(br_offset), .br_reg_val(br_reg_val), .br_target(br_target)
`ifdef FETCH_STATS_EN
    , .stat_fetched(stat_fetched), .stat_flushed(stat_flushed)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] data;
  } ent_t;

  typedef struct {
    logic        valid;
    logic [1:0]  typ;
    logic [31:0] bpc;
    logic [15:0] off;
    logic [31:0] reg_v;
    logic [31:0] tgt;
    logic        exp_taken;
    logic [31:0] exp_pc_in;
    logic [31:0] exp_addr;
  } vec_t;

  ent_t sb[$];
  vec_t vecs[8];
  int   errors = 0;
  int   checks = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic model_taken();
    return br_valid && ((br_type == 2'b10) ||
                        (br_type == 2'b01 && br_reg_val == 32'd0) ||
                        (br_type == 2'b11 && br_reg_val != 32'd0));
  endfunction

  // One clock: score any pop, follow the PC strobe, cross the edge.
  task automatic tick();
    logic [31:0] npc;
    ent_t e;
    #1;
    if (rst && model_taken()) begin
      sb.delete();
    end else if (rst && ir_valid && ir_ready) begin
      check("pop_expected", 64'(sb.size() != 0), 64'd1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        check("pop_pc", 64'(ir_pc), 64'(e.pc));
        check("pop_data", 64'(ir_data), 64'(e.data));
      end
    end
    npc = pc_cur;
    if (pc_clk_en) begin
      case (pcsel)
        2'b00:   npc = pc_in;
        2'b10:   npc = pc_address;
        default: npc = pc_in - 32'd4 + {{14{pc_offset[15]}}, pc_offset, 2'b00};
      endcase
    end
    @(posedge clk);
    #1;
    if (!rst) npc = 32'd0;
    pc_cur = npc;
    pc_nxt = npc + 32'd4;
  endtask

  task automatic wait_req();
    for (int i = 0; i < 20 && !imem_req; i++) tick();
    check("req_seen", 64'(imem_req), 64'd1);
  endtask

  // Answer the outstanding request one cycle after it is seen.
  task automatic fetch_one(input logic [31:0] addr, input logic [31:0] data);
    wait_req();
    check("imem_addr", 64'(imem_addr), 64'(addr));
    imem_ack   = 1'b1;
    imem_rdata = data;
    #1;
    check("adv_en", 64'(pc_clk_en), 64'd1);
    check("adv_sel", 64'(pcsel), 64'd0);
    check("adv_pc_in", 64'(pc_in), 64'(addr + 32'd4));
    sb.push_back('{addr, data});
    tick();
    imem_ack = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic        any_req;
    logic [31:0] s0;
    rst = 1'b0; clk_en = 1'b0; pc_cur = 32'd0; pc_nxt = 32'd4;
    imem_ack = 1'b0; imem_rdata = 32'd0; ir_ready = 1'b0;
    br_valid = 1'b0; br_type = 2'b00; br_pc = 32'd0; br_offset = 16'd0;
    br_reg_val = 32'd0; br_target = 32'd0;
    s0 = 32'd0;

    //              valid typ    bpc           off       reg      tgt       tk  pc_in       addr
    vecs[0] = '{1'b1, 2'b00, 32'h40,       16'd5,    32'd0,   32'h100,  1'b0, 32'h0,     32'h0};
    vecs[1] = '{1'b1, 2'b01, 32'h40,       16'd5,    32'd5,   32'h100,  1'b0, 32'h0,     32'h0};
    vecs[2] = '{1'b0, 2'b10, 32'h40,       16'd0,    32'd0,   32'h700,  1'b0, 32'h0,     32'h0};
    vecs[3] = '{1'b1, 2'b01, 32'h100,      16'hFFFE, 32'd0,   32'h0,    1'b1, 32'h108,   32'h0};
    vecs[4] = '{1'b1, 2'b11, 32'h20,       16'd1,    32'd7,   32'h0,    1'b1, 32'h28,    32'h7};
    vecs[5] = '{1'b1, 2'b11, 32'h20,       16'd1,    32'd0,   32'h0,    1'b0, 32'h0,     32'h0};
    vecs[6] = '{1'b1, 2'b10, 32'hFFFFFFF8, 16'd7,    32'd9,   32'h1234, 1'b1, 32'h0,     32'h1234};
    vecs[7] = '{1'b1, 2'b10, 32'h300,      16'd0,    32'd0,   32'h400,  1'b1, 32'h308,   32'h400};

    // ---- reset values, including pc_in held at 0 while pc_nxt=4
    tick(); tick();
    check("rst_req", 64'(imem_req), 64'd0);
    check("rst_addr", 64'(imem_addr), 64'd0);
    check("rst_ir", {31'd0, ir_valid, ir_data}, 64'd0);
    check("rst_ir_pc", 64'(ir_pc), 64'd0);
    check("rst_pc_ctl", {29'd0, pc_clk_en, pcsel, pc_in}, 64'd0);
    check("rst_br_ctl", {pc_offset, pc_address}, 64'd0);

    // ---- release, first issue one cycle later; then reset mid-REQ
    rst = 1'b1; clk_en = 1'b1;
    tick();
    check("first_req", 64'(imem_req), 64'd1);
    check("first_addr", 64'(imem_addr), 64'd0);
    rst = 1'b0;
    #1;
    check("midreq_rst_req", 64'(imem_req), 64'd0);
    check("midreq_rst_addr", 64'(imem_addr), 64'd0);
    tick();
    rst = 1'b1; clk_en = 1'b0;
    imem_ack = 1'b1; imem_rdata = 32'hDEAD;
    #1;
    check("late_ack_no_adv", 64'(pc_clk_en), 64'd0);
    tick();
    imem_ack = 1'b0;
    check("late_ack_no_push", 64'(ir_valid), 64'd0);

    // ---- sequential fetch, decode always ready
    clk_en = 1'b1; ir_ready = 1'b1;
    fetch_one(32'd0, 32'hA0);
    fetch_one(32'd4, 32'hA1);
    fetch_one(32'd8, 32'hA2);
    clk_en = 1'b0;
    tick(); tick();
    check("seq_drained", 64'(sb.size()), 64'd0);
    check("seq_empty", 64'(ir_valid), 64'd0);

    // ---- backpressure: two pushes fill the buffer, issue stops
    clk_en = 1'b1; ir_ready = 1'b0;
    fetch_one(32'd12, 32'hB0);
    fetch_one(32'd16, 32'hB1);
    any_req = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      any_req |= imem_req;
    end
    check("full_no_req", 64'(any_req), 64'd0);
    check("full_head_data", 64'(ir_data), 64'hB0);
    check("full_head_pc", 64'(ir_pc), 64'd12);
    ir_ready = 1'b1;
    tick();
    ir_ready = 1'b0;
    check("pop_edge_no_req", 64'(imem_req), 64'd0);
    tick();
    check("resume_req", 64'(imem_req), 64'd1);
    check("resume_addr", 64'(imem_addr), 64'h14);

    // ---- taken BEQ during REQ with B1 still buffered
    br_valid = 1'b1; br_type = 2'b01; br_pc = 32'h10; br_offset = 16'd3; br_reg_val = 32'd0;
    #1;
    check("beq_en", 64'(pc_clk_en), 64'd1);
    check("beq_sel", 64'(pcsel), 64'd1);
    check("beq_pc_in", 64'(pc_in), 64'h18);
    check("beq_off", 64'(pc_offset), 64'd3);
    tick();
    br_valid = 1'b0;
    check("beq_flushed", 64'(ir_valid), 64'd0);
    check("flush_req_held", 64'(imem_req), 64'd1);
    imem_ack = 1'b1; imem_rdata = 32'hBAD;
    #1;
    check("flush_ack_no_adv", 64'(pc_clk_en), 64'd0);
    tick();
    imem_ack = 1'b0;
    check("flush_ack_no_push", 64'(ir_valid), 64'd0);
    check("flush_to_idle", 64'(imem_req), 64'd0);
    tick();
    check("post_flush_req", 64'(imem_req), 64'd1);
    check("post_flush_addr", 64'(imem_addr), 64'h20);

    // ---- not-taken BNE leaves buffer intact
    fetch_one(32'h20, 32'hC0);
    clk_en = 1'b0;
    br_valid = 1'b1; br_type = 2'b11; br_reg_val = 32'd0;
    #1;
    check("bne_nt_en", 64'(pc_clk_en), 64'd0);
    tick();
    br_valid = 1'b0;
    check("bne_nt_valid", 64'(ir_valid), 64'd1);
    check("bne_nt_data", 64'(ir_data), 64'hC0);
    check("bne_nt_pc", 64'(ir_pc), 64'h20);

    // ---- redirect decode table, applied in IDLE with issue blocked
    foreach (vecs[i]) begin
      br_valid = vecs[i].valid; br_type = vecs[i].typ; br_pc = vecs[i].bpc;
      br_offset = vecs[i].off; br_reg_val = vecs[i].reg_v; br_target = vecs[i].tgt;
      #1;
      check($sformatf("vec%0d_en", i), 64'(pc_clk_en), 64'(vecs[i].exp_taken));
      check($sformatf("vec%0d_sel", i), 64'(pcsel),
            64'(vecs[i].exp_taken ? vecs[i].typ : 2'b00));
      check($sformatf("vec%0d_pc_in", i), 64'(pc_in),
            64'(vecs[i].exp_taken ? vecs[i].exp_pc_in : pc_nxt));
      check($sformatf("vec%0d_off", i), 64'(pc_offset),
            64'(vecs[i].exp_taken ? vecs[i].off : 16'd0));
      check($sformatf("vec%0d_addr", i), 64'(pc_address), 64'(vecs[i].exp_addr));
      tick();
      br_valid = 1'b0;
    end
    check("table_flushed", 64'(ir_valid), 64'd0);

    // ---- JMP coincident with ack: response dropped, buffer flushed
    clk_en = 1'b1; ir_ready = 1'b0;
    fetch_one(32'h400, 32'hD0);
    wait_req();
    check("jmp_req_addr", 64'(imem_addr), 64'h404);
`ifdef FETCH_STATS_EN
    s0 = stat_flushed;
`endif
    imem_ack = 1'b1; imem_rdata = 32'hE0;
    br_valid = 1'b1; br_type = 2'b10; br_pc = 32'h50; br_target = 32'h200; br_reg_val = 32'd0;
    clk_en = 1'b0;
    #1;
    check("jmp_en", 64'(pc_clk_en), 64'd1);
    check("jmp_sel", 64'(pcsel), 64'd2);
    check("jmp_addr", 64'(pc_address), 64'h200);
    check("jmp_pc_in", 64'(pc_in), 64'h58);
    tick();
    imem_ack = 1'b0; br_valid = 1'b0;
    check("jmp_dropped", 64'(ir_valid), 64'd0);
    check("jmp_idle", 64'(imem_req), 64'd0);
`ifdef FETCH_STATS_EN
    check("stat_flushed_delta", 64'(stat_flushed - s0), 64'd2);
`endif
    tick();
    check("final_sb_empty", 64'(sb.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction-fetch front end and controller for the program counter in the pipelined Beta CPU.
- Reads instruction memory at the PC's current address and buffers fetched words for decode.
- Advances the PC by strobing its clock enable, and converts execute-stage branch and jump resolution into the PC's pcsel/pc_in/offset/address controls.
- Flushes wrong-path instructions on a taken redirect.

Parameters:
DEPTH, 2, instruction buffer entries; power of two, >= 2

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-low reset
clk_en  in  1  global enable; low blocks new fetch issue only
pc_cur  in  32  PC current address (PC pc_out)
pc_nxt  in  32  PC next address (PC pc_next)
pc_clk_en  out  1  PC clock enable, combinational
pcsel  out  2  PC select, combinational: 00 NORMAL, 01 BEQ, 10 JMP, 11 BNE
pc_in  out  32  PC base input, combinational
pc_offset  out  16  branch word offset to PC
pc_address  out  32  jump target, or register value for BEQ/BNE
imem_req  out  1  memory request, registered
imem_addr  out  32  memory address, registered
imem_ack  in  1  memory response valid, 1-cycle pulse
imem_rdata  in  32  instruction word, valid with imem_ack
ir_valid  out  1  buffer head valid
ir_data  out  32  buffer head instruction
ir_pc  out  32  buffer head instruction address
ir_ready  in  1  decode accepts head
br_valid  in  1  execute-stage resolution, 1-cycle pulse
br_type  in  2  encoding as pcsel
br_pc  in  32  address of the branch instruction
br_offset  in  16  signed word offset
br_reg_val  in  32  tested register value
br_target  in  32  JMP target

Behaviour:
- Reset values:
  - State IDLE; buffer empty.
  - imem_req=0, imem_addr=0, ir_valid=0, ir_data=0, ir_pc=0.
  - pc_clk_en=0, pcsel=00, pc_in=0, pc_offset=0, pc_address=0.
  - Reset mid-request abandons the request; any late ack while in IDLE is ignored.
- Taken condition: taken = br_valid & (br_type==JMP | (br_type==BEQ & br_reg_val==0) | (br_type==BNE & br_reg_val!=0)). br_type==NORMAL is never taken.
- Default combinational outputs: pc_clk_en=0, pcsel=00, pc_in=pc_nxt, pc_offset=0, pc_address=0.
- Taken redirect (highest priority, any state), same cycle:
  - pc_clk_en=1, pcsel=br_type, pc_in=br_pc+8, pc_offset=br_offset.
  - pc_address = br_target for JMP, else br_reg_val.
  - The PC's internal -4 then yields a branch target of br_pc+4+4*offset.
  - At the clock edge the buffer is cleared (count and pointers to 0), so ir_valid=0 next cycle.
- IDLE:
  - If clk_en=1, count<DEPTH and no taken redirect: at the edge set imem_req<=1, imem_addr<=pc_cur, go to REQ.
- REQ:
  - imem_req held high until imem_ack.
  - On ack without taken: push {pc=imem_addr, data=imem_rdata}; pc_clk_en=1 with pcsel=NORMAL, pc_in=pc_nxt, the same cycle; imem_req<=0; go to IDLE.
  - On ack with taken: data discarded, redirect outputs apply, go to IDLE.
  - Taken without ack: go to FLUSH.
- FLUSH:
  - imem_req held until ack; the data is discarded with no push and no PC advance; then IDLE.
  - A further taken redirect in FLUSH redirects the PC and stays in FLUSH.
- Request rules: one outstanding request maximum; IDLE lasts at least 1 cycle between requests, so pc_cur is already updated at issue.
- Buffer:
  - ir_valid = count!=0; ir_data/ir_pc show the head.
  - Pop on ir_valid & ir_ready; push and pop in the same cycle leave count unchanged.
  - Overflow is impossible because issue requires count<DEPTH.
  - A pop in the flush cycle is superseded by the flush.
- clk_en=0: in-flight requests, pops and redirects proceed; only IDLE issue is blocked.

Optional Feature:
- Macro FETCH_STATS_EN.
- Defined: adds outputs stat_fetched[31:0] (increments per pushed instruction) and stat_flushed[31:0] (increments per discarded response, plus the buffer count at each flush). Both are 0 on reset and wrap modulo 2^32.
- Undefined: these ports and counters are absent; all other behaviour is identical.

Test Plan:
- Reset: hold rst=0 mid-REQ -> all outputs 0, state IDLE; release with pc_cur=0, pc_nxt=4 -> imem_req=1, imem_addr=0 one cycle later.
- Sequential fetch: 1-cycle ack latency, ir_ready=1, words 0xA0,0xA1,0xA2 -> pc_clk_en pulses with pc_in=4,8,12; ir_pc 0,4,8 in order.
- Backpressure: DEPTH=2, ir_ready=0 -> two pushes then imem_req stays 0; raise ir_ready -> issue resumes after the first pop.
- Taken BEQ during REQ: br_pc=0x10, offset=3, reg=0, no ack -> pcsel=01, pc_in=0x18, pc_offset=3, buffer cleared, FLUSH; ack next cycle -> nothing pushed, IDLE.
- Not-taken BNE: br_reg_val=0 -> no pc_clk_en, buffer contents intact.
- JMP coincident with ack: br_target=0x200 -> pcsel=10, pc_address=0x200, response dropped; with FETCH_STATS_EN, stat_flushed increments by 1 plus the prior count.
